mem_arbiter: RTL

- Shares the single byte-wide external RAM port between two requesters: instruction fetch (32-bit reads) and the MEM stage (1/2/4-byte reads and writes).
- Serialises each multi-byte access into consecutive byte cycles and assembles or splits the data.
- Drives per-requester done strobes and stall requests toward ctrl.
- Sits between the core's if/mem ports and the RAM model, replacing the direct data_ram hookup.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto a byte-wide RAM port. Fetch and MEM-stage
// accesses are serialised into byte cycles, and read bytes are reassembled.
module mem_arbiter #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_done,
  input  logic                  mem_re,
  input  logic                  mem_we,
  input  logic [3:0]            mem_mask,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic                  stall_req_if,
  output logic                  stall_req_mem
);

  typedef enum logic [2:0] {
    S_IDLE, S_IF_RD, S_MEM_RD, S_MEM_WR, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_k, w_k_nxt;
  logic        r_own_mem, w_own_nxt;
  logic [31:0] r_buf, r_if_rdata, r_mem_rdata;
  logic [31:0] w_merge, w_base;
  logic [2:0]  w_mem_n, w_len;
  logic        w_xfer, w_active;
  logic        w_unused;

  // Unrecognised masks fall back to a full word.
  always_comb begin
    w_mem_n = 3'd4;
    case (mem_mask)
      4'b0001: w_mem_n = 3'd1;
      4'b0011: w_mem_n = 3'd2;
      default: w_mem_n = 3'd4;
    endcase
  end

  assign w_len    = r_own_mem ? w_mem_n : 3'd4;
  assign w_base   = r_own_mem ? mem_addr : if_addr;
  assign w_xfer   = (r_state == S_IF_RD) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_active = w_xfer && (r_k < w_len);
  assign w_unused = ^w_base[31:RAM_ADDR_W];

  // Read byte k-1 arrives on ram_din while the counter reads k.
  for (genvar j = 0; j < 4; j++) begin : g_lane
    assign w_merge[8*j +: 8] = (r_k == 3'(j + 1)) ? ram_din : r_buf[8*j +: 8];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_own_nxt   = r_own_mem;
    case (r_state)
      S_IDLE: begin
        w_k_nxt = 3'd0;
        if (mem_re || mem_we) begin
          w_own_nxt   = 1'b1;
          w_state_nxt = mem_we ? S_MEM_WR : S_MEM_RD;
        end else if (if_req) begin
          w_own_nxt   = 1'b0;
          w_state_nxt = S_IF_RD;
        end
      end
      S_IF_RD, S_MEM_RD: begin
        if (r_k == w_len) begin
          w_state_nxt = S_DONE;
          w_k_nxt     = 3'd0;
        end else begin
          w_k_nxt = r_k + 3'd1;
        end
      end
      S_MEM_WR: begin
        if (r_k == w_len - 3'd1) begin
          w_state_nxt = S_DONE;
          w_k_nxt     = 3'd0;
        end else begin
          w_k_nxt = r_k + 3'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_k       <= 3'd0;
      r_own_mem <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_own_mem <= w_own_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf       <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        r_buf <= '0;
      end else if ((r_state == S_IF_RD) || (r_state == S_MEM_RD)) begin
        r_buf <= w_merge;
        if (r_k == w_len) begin
          if (r_own_mem) r_mem_rdata <= w_merge;
          else           r_if_rdata  <= w_merge;
        end
      end
    end
  end

  assign if_rdata      = r_if_rdata;
  assign mem_rdata     = r_mem_rdata;
  assign if_done       = (r_state == S_DONE) && !r_own_mem;
  assign mem_done      = (r_state == S_DONE) && r_own_mem;
  assign ram_addr      = w_active ? (w_base[RAM_ADDR_W-1:0] + RAM_ADDR_W'(r_k)) : '0;
  assign ram_wr        = (r_state == S_MEM_WR);
  assign ram_dout      = ram_wr ? mem_wdata[8*r_k[1:0] +: 8] : 8'h00;
  // Stalls are forced low while reset is held, even if a request is pending.
  assign stall_req_if  = rst && if_req && !if_done;
  assign stall_req_mem = rst && (mem_re || mem_we) && !mem_done;

endmodule
